// File: rtl/core2axi_pkg.sv
// rtl/core2axi_pkg.sv - shared AXI-Lite bundle typedefs, response codes and bridge FSM states
//
// Purpose: single home for the AXI-Lite request/response bundles used by both
//          core<->AXI-Lite bridges, plus the response encodings and bridge states.
// Ports:   none (package).
package core2axi_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef logic [AXI_ADDR_WIDTH-1:0] axi_lite_addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0] axi_lite_data_t;
  typedef logic [AXI_STRB_WIDTH-1:0] axi_lite_strb_t;

  typedef struct packed {
    axi_lite_addr_t addr;
    logic [2:0]     prot;
  } axi_lite_aw_chan_t;

  typedef struct packed {
    axi_lite_data_t data;
    axi_lite_strb_t strb;
  } axi_lite_w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_chan_t;

  typedef struct packed {
    axi_lite_addr_t addr;
    logic [2:0]     prot;
  } axi_lite_ar_chan_t;

  typedef struct packed {
    axi_lite_data_t data;
    logic [1:0]     resp;
  } axi_lite_r_chan_t;

  typedef struct packed {
    axi_lite_aw_chan_t aw;
    logic              aw_valid;
    axi_lite_w_chan_t  w;
    logic              w_valid;
    logic              b_ready;
    axi_lite_ar_chan_t ar;
    logic              ar_valid;
    logic              r_ready;
  } axi_req_t;

  typedef struct packed {
    logic              aw_ready;
    logic              w_ready;
    axi_lite_b_chan_t  b;
    logic              b_valid;
    logic              ar_ready;
    axi_lite_r_chan_t  r;
    logic              r_valid;
  } axi_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_B_RESP = 3'd3,
    ST_R_RESP = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_to_mem_struct_bridge_if.sv
// rtl/axi_lite_to_mem_struct_bridge_if.sv - AXI-Lite struct bundle interface for the bridge
//
// Purpose: carries the bundled AXI-Lite request/response pair between a manager
//          and the bridge.
// Ports:   none; members req (manager -> subordinate), resp (subordinate -> manager).
interface axi_lite_to_mem_struct_bridge_if;
  import core2axi_pkg::*;

  axi_req_t  req;
  axi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/axi_lite_to_mem_struct_bridge.sv
// rtl/axi_lite_to_mem_struct_bridge.sv - AXI-Lite subordinate replayed onto the core req/gnt/rvalid memory port
//
// Purpose: accepts one AXI-Lite read or write at a time and issues it as a single
//          memory request, returning the memory response as B or R.
// Ports:   clk_i, rst_ni          clock, asynchronous active-low reset
//          axi_req_i/axi_resp_o   AXI-Lite request/response bundles
//          mem_req_o/mem_gnt_i    memory request handshake
//          mem_rvalid_i/mem_err_i memory response and its error flag
//          mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o/mem_rdata_i  memory payload
module axi_lite_to_mem_struct_bridge
  import core2axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                axi_req_i,
  output axi_resp_t               axi_resp_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic                    mem_err_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  bridge_state_e         state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic                  mem_req_q, mem_req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  axi_lite_data_t        rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  b_valid_q, b_valid_d;
  logic                  r_valid_q, r_valid_d;

  logic wr_elig, rd_elig, accept_wr, accept_rd;

  // Protection bits carry no meaning for the memory port.
  logic unused_prot;
  assign unused_prot = ^{axi_req_i.aw.prot, axi_req_i.ar.prot};

  // AW and W are only taken together; on a tie prio_wr_q chooses the winner.
  assign wr_elig   = axi_req_i.aw_valid & axi_req_i.w_valid;
  assign rd_elig   = axi_req_i.ar_valid;
  assign accept_wr = (state_q == ST_IDLE) & wr_elig & (~rd_elig | prio_wr_q);
  assign accept_rd = (state_q == ST_IDLE) & rd_elig & (~wr_elig | ~prio_wr_q);

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    mem_req_d = mem_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    b_valid_d = b_valid_q;
    r_valid_d = r_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_wr) begin
          addr_d    = ADDR_WIDTH'(axi_req_i.aw.addr);
          wdata_d   = DATA_WIDTH'(axi_req_i.w.data);
          be_d      = BE_WIDTH'(axi_req_i.w.strb);
          we_d      = 1'b1;
          mem_req_d = 1'b1;
          prio_wr_d = ~prio_wr_q;
          state_d   = ST_REQ;
        end else if (accept_rd) begin
          addr_d    = ADDR_WIDTH'(axi_req_i.ar.addr);
          be_d      = '1;
          we_d      = 1'b0;
          mem_req_d = 1'b1;
          prio_wr_d = ~prio_wr_q;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = axi_lite_data_t'(mem_rdata_i);
          resp_d  = mem_err_i ? RESP_SLVERR : RESP_OKAY;
          if (we_q) begin
            b_valid_d = 1'b1;
            state_d   = ST_B_RESP;
          end else begin
            r_valid_d = 1'b1;
            state_d   = ST_R_RESP;
          end
        end
      end
      ST_B_RESP: begin
        if (axi_req_i.b_ready) begin
          b_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_R_RESP: begin
        if (axi_req_i.r_ready) begin
          r_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b1;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      mem_req_q <= mem_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      b_valid_q <= b_valid_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = accept_wr;
    axi_resp_o.w_ready  = accept_wr;
    axi_resp_o.ar_ready = accept_rd;
    axi_resp_o.b.resp   = resp_q;
    axi_resp_o.b_valid  = b_valid_q;
    axi_resp_o.r.data   = rdata_q;
    axi_resp_o.r.resp   = resp_q;
    axi_resp_o.r_valid  = r_valid_q;
  end

endmodule

// File: tb/tb_axi_lite_to_mem_struct_bridge.sv
// tb/tb_axi_lite_to_mem_struct_bridge.sv - directed self-checking bench for the AXI-Lite to memory bridge
module tb_axi_lite_to_mem_struct_bridge;
  import core2axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  axi_lite_to_mem_struct_bridge_if bus ();

  axi_lite_to_mem_struct_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .axi_req_i    (bus.req),
    .axi_resp_o   (bus.resp),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_err_i    (mem_err),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req    = '0;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset state
    smp();
    chk_eq("rst_resp", 64'(bus.resp), 64'd0);
    chk_eq("rst_req", mem_req, 1'b0);
    chk_eq("rst_we", mem_we, 1'b0);
    chk_eq("rst_addr", mem_addr, 32'd0);
    chk_eq("rst_wdata", mem_wdata, 32'd0);
    chk_eq("rst_be", mem_be, 4'd0);

    // Write 0x100, best-case latency
    tick();
    bus.req.aw.addr = 32'h100; bus.req.aw_valid = 1'b1;
    bus.req.w.data = 32'hDEADBEEF; bus.req.w.strb = 4'hF; bus.req.w_valid = 1'b1;
    bus.req.b_ready = 1'b1;
    smp();
    chk_eq("wr_aw_ready", bus.resp.aw_ready, 1'b1);
    chk_eq("wr_w_ready", bus.resp.w_ready, 1'b1);
    chk_eq("wr_ar_ready", bus.resp.ar_ready, 1'b0);
    tick();
    bus.req.aw_valid = 1'b0; bus.req.w_valid = 1'b0;
    smp();
    chk_eq("wr_mem_req", mem_req, 1'b1);
    chk_eq("wr_mem_we", mem_we, 1'b1);
    chk_eq("wr_mem_addr", mem_addr, 32'h100);
    chk_eq("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk_eq("wr_mem_be", mem_be, 4'hF);
    tick();
    mem_rvalid = 1'b1; mem_rdata = '0; mem_err = 1'b0;
    smp();
    chk_eq("wr_b_early", bus.resp.b_valid, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk_eq("wr_b_valid_c3", bus.resp.b_valid, 1'b1);
    chk_eq("wr_b_resp", bus.resp.b.resp, RESP_OKAY);
    chk_eq("wr_req_done", mem_req, 1'b0);
    tick();
    smp();
    chk_eq("wr_b_cleared", bus.resp.b_valid, 1'b0);

    // Read 0x104 with r_ready held low for 5 cycles
    tick();
    bus.req.ar.addr = 32'h104; bus.req.ar_valid = 1'b1; bus.req.r_ready = 1'b0;
    smp();
    chk_eq("rd_ar_ready", bus.resp.ar_ready, 1'b1);
    chk_eq("rd_aw_ready", bus.resp.aw_ready, 1'b0);
    tick();
    bus.req.ar_valid = 1'b0;
    smp();
    chk_eq("rd_mem_req", mem_req, 1'b1);
    chk_eq("rd_mem_we", mem_we, 1'b0);
    chk_eq("rd_mem_addr", mem_addr, 32'h104);
    chk_eq("rd_mem_be", mem_be, 4'hF);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    smp();
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk_eq("rd_hold_valid", bus.resp.r_valid, 1'b1);
      chk_eq("rd_hold_data", bus.resp.r.data, 32'h12345678);
      chk_eq("rd_hold_resp", bus.resp.r.resp, RESP_OKAY);
      tick();
    end
    bus.req.r_ready = 1'b1;
    smp();
    chk_eq("rd_valid_at_ready", bus.resp.r_valid, 1'b1);
    tick();
    bus.req.r_ready = 1'b0;
    smp();
    chk_eq("rd_valid_cleared", bus.resp.r_valid, 1'b0);

    // Simultaneous write 0x200 / read 0x204, alternating service
    tick();
    bus.req.aw.addr = 32'h200; bus.req.w.data = 32'h0000C0DE; bus.req.w.strb = 4'hF;
    bus.req.ar.addr = 32'h204;
    bus.req.aw_valid = 1'b1; bus.req.w_valid = 1'b1; bus.req.ar_valid = 1'b1;
    bus.req.b_ready = 1'b1; bus.req.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_wr;
      exp_wr = (i % 2 == 0);
      smp();
      chk_eq("arb_aw_ready", bus.resp.aw_ready, exp_wr);
      chk_eq("arb_ar_ready", bus.resp.ar_ready, !exp_wr);
      tick();
      smp();
      chk_eq("arb_mem_addr", mem_addr, exp_wr ? 32'h200 : 32'h204);
      chk_eq("arb_mem_we", mem_we, exp_wr);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(i);
      smp();
      tick();
      mem_rvalid = 1'b0;
      smp();
      chk_eq("arb_b_valid", bus.resp.b_valid, exp_wr);
      chk_eq("arb_r_valid", bus.resp.r_valid, !exp_wr);
      if (!exp_wr) chk_eq("arb_r_data", bus.resp.r.data, 32'hA0 + 32'(i));
      tick();
      if (i == 3) begin
        bus.req.aw_valid = 1'b0; bus.req.w_valid = 1'b0; bus.req.ar_valid = 1'b0;
      end
    end
    smp();

    // AW without W for 4 cycles
    tick();
    bus.req.aw.addr = 32'h180; bus.req.aw_valid = 1'b1;
    bus.req.w.data = 32'h55AA55AA; bus.req.w.strb = 4'h3; bus.req.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk_eq("aw_only_aw_ready", bus.resp.aw_ready, 1'b0);
      chk_eq("aw_only_w_ready", bus.resp.w_ready, 1'b0);
      tick();
    end
    bus.req.w_valid = 1'b1;
    smp();
    chk_eq("aw_w_aw_ready", bus.resp.aw_ready, 1'b1);
    chk_eq("aw_w_w_ready", bus.resp.w_ready, 1'b1);
    tick();
    bus.req.aw_valid = 1'b0; bus.req.w_valid = 1'b0;
    smp();
    chk_eq("aw_w_mem_addr", mem_addr, 32'h180);
    chk_eq("aw_w_mem_be", mem_be, 4'h3);
    chk_eq("aw_w_mem_wdata", mem_wdata, 32'h55AA55AA);
    tick();
    mem_rvalid = 1'b1;
    smp();
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk_eq("aw_w_b_valid", bus.resp.b_valid, 1'b1);
    tick();
    smp();

    // Read 0x300, grant stalled 3 cycles, stray rvalid during stall, err response
    tick();
    mem_gnt = 1'b0;
    bus.req.ar.addr = 32'h300; bus.req.ar_valid = 1'b1; bus.req.r_ready = 1'b1;
    smp();
    chk_eq("stall_ar_ready", bus.resp.ar_ready, 1'b1);
    tick();
    bus.req.ar_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk_eq("stall_mem_req", mem_req, 1'b1);
      chk_eq("stall_mem_addr", mem_addr, 32'h300);
      chk_eq("stall_mem_we", mem_we, 1'b0);
      chk_eq("stall_mem_be", mem_be, 4'hF);
      tick();
      if (i == 0) mem_rvalid = 1'b1;
      if (i == 1) mem_rvalid = 1'b0;
      if (i == 2) mem_gnt = 1'b1;
    end
    smp();
    chk_eq("stall_gnt_req", mem_req, 1'b1);
    chk_eq("stall_no_r", bus.resp.r_valid, 1'b0);
    tick();
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hBAD0BAD0;
    smp();
    chk_eq("stall_req_done", mem_req, 1'b0);
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    smp();
    chk_eq("err_r_valid", bus.resp.r_valid, 1'b1);
    chk_eq("err_r_resp", bus.resp.r.resp, RESP_SLVERR);
    chk_eq("err_r_data", bus.resp.r.data, 32'hBAD0BAD0);
    tick();
    smp();
    chk_eq("err_r_cleared", bus.resp.r_valid, 1'b0);

    // Reset asserted while waiting for the memory response
    tick();
    bus.req.aw.addr = 32'h400; bus.req.w.data = 32'h11112222; bus.req.w.strb = 4'hF;
    bus.req.aw_valid = 1'b1; bus.req.w_valid = 1'b1; bus.req.b_ready = 1'b1;
    smp();
    chk_eq("abort_aw_ready", bus.resp.aw_ready, 1'b1);
    tick();
    bus.req.aw_valid = 1'b0; bus.req.w_valid = 1'b0;
    smp();
    chk_eq("abort_mem_req", mem_req, 1'b1);
    tick();
    rst_ni = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1;
    chk_eq("abort_req", mem_req, 1'b0);
    chk_eq("abort_we", mem_we, 1'b0);
    chk_eq("abort_addr", mem_addr, 32'd0);
    chk_eq("abort_wdata", mem_wdata, 32'd0);
    chk_eq("abort_be", mem_be, 4'd0);
    chk_eq("abort_resp", 64'(bus.resp), 64'd0);
    smp();
    tick();
    rst_ni = 1'b1;
    smp();
    chk_eq("abort_post_resp", 64'(bus.resp), 64'd0);
    chk_eq("abort_post_req", mem_req, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk_eq("abort_no_b", bus.resp.b_valid, 1'b0);
      chk_eq("abort_no_r", bus.resp.r_valid, 1'b0);
      tick();
    end

    // Normal read after the aborted transaction
    bus.req.ar.addr = 32'h104; bus.req.ar_valid = 1'b1; bus.req.r_ready = 1'b1;
    smp();
    chk_eq("post_ar_ready", bus.resp.ar_ready, 1'b1);
    tick();
    bus.req.ar_valid = 1'b0;
    smp();
    chk_eq("post_mem_req", mem_req, 1'b1);
    chk_eq("post_mem_addr", mem_addr, 32'h104);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    smp();
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk_eq("post_r_valid", bus.resp.r_valid, 1'b1);
    chk_eq("post_r_data", bus.resp.r.data, 32'hCAFEF00D);
    chk_eq("post_r_resp", bus.resp.r.resp, RESP_OKAY);
    tick();
    smp();
    chk_eq("post_r_cleared", bus.resp.r_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_to_mem_struct_bridge.md
# axi_lite_to_mem_struct_bridge

AXI4-Lite subordinate that accepts bundled `axi_req_t` / `axi_resp_t` traffic and replays it as single-beat transactions on the core-style memory protocol (`req`/`gnt`/`rvalid`). It is the responder counterpart of the core-to-AXI-Lite bridge. It sits in front of scratchpad SRAMs and register files that speak the core data-port protocol. One transaction is in flight at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width of both sides.
- `DATA_WIDTH`, 32, data width of both sides; byte enables are `DATA_WIDTH/8` bits wide.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `axi_req_i`  in  `axi_req_t`  AXI-Lite request bundle: aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready.
- `axi_resp_o`  out  `axi_resp_t`  AXI-Lite response bundle: aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid.
- `mem_req_o`  out  1  memory request.
- `mem_gnt_i`  in  1  memory grant.
- `mem_rvalid_i`  in  1  memory response valid; asserted for both reads and writes.
- `mem_err_i`  in  1  memory error, qualified by `mem_rvalid_i`.
- `mem_addr_o`  out  `ADDR_WIDTH`  byte address.
- `mem_we_o`  out  1  1 = write.
- `mem_be_o`  out  `DATA_WIDTH/8`  byte enables.
- `mem_wdata_o`  out  `DATA_WIDTH`  write data.
- `mem_rdata_i`  in  `DATA_WIDTH`  read data, qualified by `mem_rvalid_i`.

## Operation
- FSM states: IDLE, REQ, WAIT, B_RESP, R_RESP.
- IDLE:
  - A write is eligible when aw_valid and w_valid are both 1.
  - A read is eligible when ar_valid is 1.
  - If only one kind is eligible, that kind is accepted.
  - If both are eligible, the `prio_wr` flag picks the winner. `prio_wr` resets to 1 (write first) and toggles after every accepted transaction.
- Write accept: aw_ready and w_ready are both 1 in the same cycle. AW and W are never accepted separately. Latch aw.addr, w.data, w.strb, and set we=1. Next state is REQ.
- Read accept: ar_ready is 1. Latch ar.addr, set be to all ones and we=0. Next state is REQ.
- aw.prot and ar.prot are ignored. The address passes through unmodified, with no alignment.
- REQ:
  - `mem_req_o`=1 with the latched addr, we, be and wdata.
  - These outputs stay stable until `mem_gnt_i`=1.
  - On gnt, go to WAIT.
- WAIT:
  - On `mem_rvalid_i`, capture rdata and err.
  - Go to B_RESP if we=1, else R_RESP.
  - `mem_rvalid_i` outside WAIT is ignored.
- B_RESP:
  - b_valid=1; b.resp = SLVERR (2'b10) if err, else OKAY.
  - Hold until b_ready, then go to IDLE.
- R_RESP:
  - r_valid=1 with the captured r.data; r.resp is set as in B_RESP.
  - Data and resp stay stable until r_ready, then go to IDLE.
- Ready and valid are never combinationally dependent on the partner's ready.

## Timing
- Reset values:
  - All `axi_resp_o` fields are 0.
  - `mem_req_o`, `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wdata_o` are 0.
  - State is IDLE and `prio_wr`=1.
- The ready signals are combinational from the valids, and are asserted only in IDLE.
- Best-case latency, with gnt tied high and rvalid arriving the cycle after gnt:
  - AXI handshake in cycle 0.
  - mem_req in cycle 1.
  - rvalid in cycle 2.
  - b_valid/r_valid in cycle 3.
- Response to a new accept: if b_ready/r_ready is already 1 in cycle 3, IDLE is re-entered in cycle 4 and a new accept is possible in cycle 4.
- The memory side guarantees that rvalid never arrives in the same cycle as gnt. The bridge does not need to handle that case.
- Asynchronous reset mid-transaction:
  - The FSM returns to IDLE immediately.
  - Any pending memory response is discarded.
  - No B or R response is issued for the aborted transaction.

## Structure
- The typedefs `axi_lite_addr_t`, `axi_lite_data_t`, `axi_lite_strb_t`, `axi_req_t` and `axi_resp_t` live in a shared package `core2axi_pkg`. Both bridges import it, so the `AXI_LITE_TYPEDEF_ALL_CT` expansion exists exactly once.
- The response constants `RESP_OKAY` and `RESP_SLVERR` are defined in the same package.
- Single module, no sub-modules: the FSM, latch registers and arbitration flag are inline.

## Test plan
- Write: addr 0x100, data 0xDEADBEEF, strb 0xF, gnt and rvalid immediate.
  - Expect mem_req/we/addr/wdata/be to match.
  - Expect b_valid with OKAY in cycle 3.
- Read: addr 0x104, memory returns 0x12345678 with err=0.
  - Expect r_valid with data 0x12345678 and OKAY.
  - r_ready held low for 5 cycles: data must stay stable across all 5.
- AW valid without W for 4 cycles:
  - Expect aw_ready=0 throughout.
  - When W arrives, expect aw_ready and w_ready together in one cycle.
- Write (0x200) and read (0x204) valid simultaneously, repeated twice:
  - Order served is write, read, write, read.
- Read at 0x300 with gnt delayed 3 cycles and rvalid carrying err=1:
  - Expect mem outputs stable during the stall.
  - Expect r.resp = SLVERR.
- Assert rst_ni low while in WAIT:
  - Expect all outputs 0 immediately.
  - Expect no B or R response.
  - Next transaction completes normally.
